// File: rtl/multicycle_control_unit_if.sv
// Shared instruction/data memory handshake.
// Controller (master) drives the request and address select; memory (slave) answers with memReady.
interface multicycle_control_unit_if;
  logic memRead;
  logic memWrite;
  logic adrSrc;
  logic memReady;

  modport master (
    output memRead,
    output memWrite,
    output adrSrc,
    input  memReady
  );

  modport slave (
    input  memRead,
    input  memWrite,
    input  adrSrc,
    output memReady
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback
// sequencing, memory wait timeout, sticky fault halt, retire counter.
// Ports: clk, rst (sync, active-high), mem (master handshake),
// opcode, zero in; datapath selects/enables, retired, instrCount,
// halted, errCode out.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int SUPPORT_JAL = 1,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_unit_if.master mem,
  input  logic [6:0]             opcode,
  input  logic                   zero,
  output logic                   irWrite,
  output logic                   pcWrite,
  output logic                   regWrite,
  output logic [1:0]             aluSrcA,
  output logic [1:0]             aluSrcB,
  output logic [1:0]             resultSrc,
  output logic [1:0]             aluOp,
  output logic                   retired,
  output logic [CNT_W-1:0]       instrCount,
  output logic                   halted,
  output logic [1:0]             errCode
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  // Counter only needs to reach MEM_TIMEOUT-1: the cycle that would
  // make it MEM_TIMEOUT is the one that faults.
  localparam int WW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] LIMIT =
    WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    err_q, err_d;
  logic [WW-1:0] wait_q, wait_d;

  logic rd_c, wr_c, adr_c;
  logic mem_state, waiting, timeout;
  logic is_r, is_i, is_l, is_s, is_b, is_j;

  assign is_r = (opcode == OP_R);
  assign is_i = (opcode == OP_I);
  assign is_l = (opcode == OP_L);
  assign is_s = (opcode == OP_S);
  assign is_b = (opcode == OP_B);
  assign is_j = (SUPPORT_JAL != 0) && (opcode == OP_JAL);

  assign mem_state = (state_q == S_FETCH)
                  || (state_q == S_MEMREAD)
                  || (state_q == S_MEMWRITE);
  assign waiting = mem_state && !mem.memReady;
  // memReady in the limit cycle is not "waiting", so it wins.
  assign timeout = (MEM_TIMEOUT != 0) && waiting
                && (wait_q == LIMIT);

  always_comb begin
    wait_d = '0;
    if ((MEM_TIMEOUT != 0) && waiting && !timeout)
      wait_d = wait_q + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      err_q      <= ERR_NONE;
      wait_q     <= '0;
      instrCount <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      if (retired)
        instrCount <= instrCount + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    adr_c     = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    resultSrc = 2'b00;
    aluOp     = 2'b00;
    retired   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        rd_c = 1'b1;
        if (mem.memReady) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          aluSrcB   = 2'b10;
          resultSrc = 2'b10;
          state_d   = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TMO;
        end
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        unique case (1'b1)
          is_l, is_s: state_d = S_MEMADR;
          is_r:       state_d = S_EXECR;
          is_i:       state_d = S_EXECI;
          is_b:       state_d = S_BRANCH;
          is_j:       state_d = S_JAL;
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILL;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        state_d = is_s ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        rd_c  = 1'b1;
        adr_c = 1'b1;
        if (mem.memReady) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TMO;
        end
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        retired   = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        wr_c  = 1'b1;
        adr_c = 1'b1;
        if (mem.memReady) begin
          retired = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TMO;
        end
      end
      S_EXECR: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        retired  = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b01;
        pcWrite = zero;
        retired = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Reset drops any in-flight request and all write strobes
    // in the same cycle, not just from the next edge onward.
    if (rst) begin
      rd_c      = 1'b0;
      wr_c      = 1'b0;
      adr_c     = 1'b0;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      regWrite  = 1'b0;
      aluSrcA   = 2'b00;
      aluSrcB   = 2'b00;
      resultSrc = 2'b00;
      aluOp     = 2'b00;
      retired   = 1'b0;
    end
  end

  assign mem.memRead  = rd_c;
  assign mem.memWrite = wr_c;
  assign mem.adrSrc   = adr_c;
  assign halted       = (state_q == S_HALT);
  assign errCode      = err_q;

endmodule
